// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Constants and types shared by the systolic-array controller
//               and its result drain path.
//               DATA_W - width of one result word (IEEE-754 single)
//               N_OUT  - result words produced per capture
//               drain_state_e - drain FSM encoding (IDLE / DRAIN)
//               idx_width()   - clog2 with a floor of 1, for index buses
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int DATA_W = 32;
    localparam int N_OUT  = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_e;

    // Index width for n entries; a single-entry bank still needs a 1-bit index.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_bank.sv
`default_nettype none
// ============================================================================
// Module      : result_bank
// Description : N_OUT x DATA_W holding register with parallel load from a
//               packed bus, an occupied flag and a word-select read port.
// Ports       : clk        - system clock
//               reset      - synchronous active-high reset (clears occupied)
//               load_i     - load data_i into the bank, mark occupied
//               clear_i    - mark bank empty (load_i has priority)
//               data_i     - packed words, word k at [k*DATA_W +: DATA_W]
//               rd_idx_i   - word select for rd_data_o
//               rd_data_o  - selected word
//               data_o     - whole bank, same packing as data_i
//               occupied_o - bank holds an undrained capture
// Revision    : 1.0 - initial release
// ============================================================================
module result_bank #(
    parameter int DATA_W = 32,
    parameter int N_OUT  = 4,
    parameter int IDX_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_i,
    input  logic                    clear_i,
    input  logic [N_OUT*DATA_W-1:0] data_i,
    input  logic [IDX_W-1:0]        rd_idx_i,
    output logic [DATA_W-1:0]       rd_data_o,
    output logic [N_OUT*DATA_W-1:0] data_o,
    output logic                    occupied_o
);

    logic [N_OUT*DATA_W-1:0] words_q;
    logic                    occupied_q;

    // Word storage needs no reset: it is only observed while occupied.
    always_ff @(posedge clk) begin
        if (load_i) begin
            words_q <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupied_q <= 1'b0;
        end else if (load_i) begin
            occupied_q <= 1'b1;
        end else if (clear_i) begin
            occupied_q <= 1'b0;
        end
    end

    assign rd_data_o  = words_q[int'(rd_idx_i) * DATA_W +: DATA_W];
    assign data_o     = words_q;
    assign occupied_o = occupied_q;

endmodule
`default_nettype wire

// File: rtl/result_drain.sv
`default_nettype none
// ============================================================================
// Module      : result_drain
// Description : Captures N_OUT result words on a done strobe into a
//               double-buffered bank (active + pending) and streams them out
//               in index order on a valid/ready interface.
// Ports       : clk       - system clock
//               reset     - synchronous active-high reset
//               done      - single-cycle capture strobe
//               res_bus   - packed result words, word 0 in the LSBs
//               out_valid - out_data holds a valid word
//               out_ready - consumer accepts the word this cycle
//               out_data  - current result word
//               out_idx   - index of out_data within its capture
//               out_last  - out_valid on word N_OUT-1
//               busy      - active or pending bank occupied (registered)
//               overrun   - sticky: a capture was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module result_drain #(
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int N_OUT  = systolic_pkg::N_OUT,
    parameter int IDX_W  = systolic_pkg::idx_width(systolic_pkg::N_OUT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    done,
    input  logic [N_OUT*DATA_W-1:0] res_bus,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overrun
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_OUT - 1);

    systolic_pkg::drain_state_e state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       overrun_q, overrun_d;
    logic                       busy_q;

    logic                       w_hs, w_last_hs;
    logic                       w_act_load, w_act_clear, w_act_from_pend;
    logic                       w_pend_load, w_pend_clear;
    logic                       w_act_occ, w_pend_occ;
    logic                       w_act_occ_next, w_pend_occ_next;
    logic [N_OUT*DATA_W-1:0]    w_act_src;
    logic [N_OUT*DATA_W-1:0]    w_pend_data;
    logic [N_OUT*DATA_W-1:0]    w_act_data_unused;
    logic [DATA_W-1:0]          w_pend_word_unused;
    logic [DATA_W-1:0]          w_act_word;

    assign out_valid = (state_q == systolic_pkg::ST_DRAIN);
    assign w_hs      = out_valid && out_ready;
    assign w_last_hs = w_hs && (idx_q == c_LAST_IDX);

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        overrun_d       = overrun_q;
        w_act_load      = 1'b0;
        w_act_clear     = 1'b0;
        w_act_from_pend = 1'b0;
        w_pend_load     = 1'b0;
        w_pend_clear    = 1'b0;

        case (state_q)
            systolic_pkg::ST_IDLE: begin
                if (done) begin
                    w_act_load = 1'b1;
                    idx_d      = '0;
                    state_d    = systolic_pkg::ST_DRAIN;
                end
            end

            systolic_pkg::ST_DRAIN: begin
                if (w_last_hs) begin
                    // Reload on the final beat so the stream never bubbles.
                    idx_d = '0;
                    if (w_pend_occ) begin
                        w_act_load      = 1'b1;
                        w_act_from_pend = 1'b1;
                        if (done) begin
                            w_pend_load = 1'b1;
                        end else begin
                            w_pend_clear = 1'b1;
                        end
                    end else if (done) begin
                        w_act_load = 1'b1;
                    end else begin
                        w_act_clear = 1'b1;
                        state_d     = systolic_pkg::ST_IDLE;
                    end
                end else begin
                    if (w_hs) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (done) begin
                        if (!w_pend_occ) begin
                            w_pend_load = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = systolic_pkg::ST_IDLE;
            end
        endcase
    end

    assign w_act_src       = w_act_from_pend ? w_pend_data : res_bus;
    assign w_act_occ_next  = w_act_load  || (w_act_occ  && !w_act_clear);
    assign w_pend_occ_next = w_pend_load || (w_pend_occ && !w_pend_clear);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= systolic_pkg::ST_IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            busy_q    <= w_act_occ_next || w_pend_occ_next;
        end
    end

    result_bank #(
        .DATA_W (DATA_W),
        .N_OUT  (N_OUT),
        .IDX_W  (IDX_W)
    ) u_active (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_act_load),
        .clear_i    (w_act_clear),
        .data_i     (w_act_src),
        .rd_idx_i   (idx_q),
        .rd_data_o  (w_act_word),
        .data_o     (w_act_data_unused),
        .occupied_o (w_act_occ)
    );

    result_bank #(
        .DATA_W (DATA_W),
        .N_OUT  (N_OUT),
        .IDX_W  (IDX_W)
    ) u_pending (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_pend_load),
        .clear_i    (w_pend_clear),
        .data_i     (res_bus),
        .rd_idx_i   ('0),
        .rd_data_o  (w_pend_word_unused),
        .data_o     (w_pend_data),
        .occupied_o (w_pend_occ)
    );

    // Bank contents are not reset, so gate the data path with valid to keep
    // out_data at zero whenever nothing is being presented.
    assign out_data = out_valid ? w_act_word : '0;
    assign out_idx  = idx_q;
    assign out_last = out_valid && (idx_q == c_LAST_IDX);
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_drain
// Description : Self-checking bench for result_drain: table-driven single
//               captures plus directed multi-cycle sequences, with a
//               scoreboard checking every accepted output beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_drain;

    localparam int c_DATA_W = 32;
    localparam int c_N_OUT  = 4;
    localparam int c_IDX_W  = 2;

    logic                        clk;
    logic                        reset;
    logic                        done;
    logic [c_N_OUT*c_DATA_W-1:0] res_bus;
    logic                        out_valid;
    logic                        out_ready;
    logic [c_DATA_W-1:0]         out_data;
    logic [c_IDX_W-1:0]          out_idx;
    logic                        out_last;
    logic                        busy;
    logic                        overrun;

    int n_total;
    int n_pass;

    logic [31:0] sb_q[$];
    logic [31:0] sb_exp;

    typedef struct {
        logic [127:0] bus;
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic [31:0]  w2;
        logic [31:0]  w3;
    } vec_t;

    vec_t vecs [3];

    result_drain #(
        .DATA_W (c_DATA_W),
        .N_OUT  (c_N_OUT),
        .IDX_W  (c_IDX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .done      (done),
        .res_bus   (res_bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard: every accepted beat must match the next expected word.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected actual=%h required=none", out_data);
            end else begin
                sb_exp = sb_q.pop_front();
                check("sb_data", out_data, sb_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [127:0] bus, input bit expect_accept,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
        done    = 1'b1;
        res_bus = bus;
        if (expect_accept) begin
            sb_q.push_back(w0);
            sb_q.push_back(w1);
            sb_q.push_back(w2);
            sb_q.push_back(w3);
        end
    endtask

    task automatic do_reset();
        out_ready = 1'b0;
        done      = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        sb_q.delete();
    endtask

    function automatic logic [31:0] vec_word(input vec_t v, input int k);
        case (k)
            0:       return v.w0;
            1:       return v.w1;
            2:       return v.w2;
            default: return v.w3;
        endcase
    endfunction

    initial begin
        n_total   = 0;
        n_pass    = 0;
        reset     = 1'b1;
        done      = 1'b0;
        res_bus   = '0;
        out_ready = 1'b0;

        vecs[0] = '{128'h40800000_40400000_40000000_3f800000,
                    32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000};
        vecs[1] = '{128'hffffffff_00000000_a5a5a5a5_5a5a5a5a,
                    32'h5a5a5a5a, 32'ha5a5a5a5, 32'h00000000, 32'hffffffff};
        vecs[2] = '{128'h80000000_7f800000_00000001_deadbeef,
                    32'hdeadbeef, 32'h00000001, 32'h7f800000, 32'h80000000};

        // Reset state
        do_reset();
        check("rst_valid",   {31'd0, out_valid}, 32'd0);
        check("rst_data",    out_data, 32'd0);
        check("rst_idx",     {30'd0, out_idx}, 32'd0);
        check("rst_last",    {31'd0, out_last}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);

        // Single captures with ready held high: latency 1, one word per cycle
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            capture(vecs[v].bus, 1'b1, vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].w3);
            tick();
            done = 1'b0;
            check("t1_busy_rise", {31'd0, busy}, 32'd1);
            for (int k = 0; k < 4; k++) begin
                check("t1_valid", {31'd0, out_valid}, 32'd1);
                check("t1_idx",   {30'd0, out_idx}, k);
                check("t1_data",  out_data, vec_word(vecs[v], k));
                check("t1_last",  {31'd0, out_last}, (k == 3) ? 32'd1 : 32'd0);
                tick();
            end
            check("t1_valid_end", {31'd0, out_valid}, 32'd0);
            check("t1_busy_end",  {31'd0, busy}, 32'd0);
        end

        // Backpressure: ready low for 3 cycles while idx 1 is presented
        capture(vecs[0].bus, 1'b1, vecs[0].w0, vecs[0].w1, vecs[0].w2, vecs[0].w3);
        tick();
        done = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_data",  out_data, 32'h40000000);
            check("bp_idx",   {30'd0, out_idx}, 32'd1);
            check("bp_last",  {31'd0, out_last}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            check("bp_resume_idx", {30'd0, out_idx}, k);
            tick();
        end
        check("bp_valid_end", {31'd0, out_valid}, 32'd0);

        // Back-to-back captures, then a dropped third capture
        capture(vecs[0].bus, 1'b1, vecs[0].w0, vecs[0].w1, vecs[0].w2, vecs[0].w3);
        tick();
        capture(128'h00000014_00000013_00000012_00000011, 1'b1,
                32'h11, 32'h12, 32'h13, 32'h14);
        tick();
        out_ready = 1'b0;
        capture(128'hcccccccc_cccccccc_cccccccc_cccccccc, 1'b0, '0, '0, '0, '0);
        tick();
        done = 1'b0;
        check("b2b_overrun_set", {31'd0, overrun}, 32'd1);
        check("b2b_stall_idx",   {30'd0, out_idx}, 32'd1);
        out_ready = 1'b1;
        for (int n = 0; n < 7; n++) begin
            check("b2b_valid", {31'd0, out_valid}, 32'd1);
            check("b2b_idx",   {30'd0, out_idx}, (n < 3) ? n + 1 : n - 3);
            tick();
        end
        check("b2b_valid_end",    {31'd0, out_valid}, 32'd0);
        check("b2b_overrun_held", {31'd0, overrun}, 32'd1);
        check("b2b_sb_drained",   sb_q.size(), 32'd0);

        // Coincident done with the last-word handshake, pending empty
        do_reset();
        check("coin_overrun_cleared", {31'd0, overrun}, 32'd0);
        out_ready = 1'b1;
        capture(vecs[1].bus, 1'b1, vecs[1].w0, vecs[1].w1, vecs[1].w2, vecs[1].w3);
        tick();
        done = 1'b0;
        tick();
        tick();
        tick();
        check("coin_at_last", {31'd0, out_last}, 32'd1);
        capture(vecs[2].bus, 1'b1, vecs[2].w0, vecs[2].w1, vecs[2].w2, vecs[2].w3);
        tick();
        done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("coin_valid", {31'd0, out_valid}, 32'd1);
            check("coin_idx",   {30'd0, out_idx}, k);
            check("coin_data",  out_data, vec_word(vecs[2], k));
            tick();
        end
        check("coin_valid_end", {31'd0, out_valid}, 32'd0);
        check("coin_overrun",   {31'd0, overrun}, 32'd0);

        // Reset mid-drain with pending full
        capture(vecs[0].bus, 1'b1, vecs[0].w0, vecs[0].w1, vecs[0].w2, vecs[0].w3);
        tick();
        capture(vecs[1].bus, 1'b1, vecs[1].w0, vecs[1].w1, vecs[1].w2, vecs[1].w3);
        tick();
        done = 1'b0;
        tick();
        check("mid_idx_before", {30'd0, out_idx}, 32'd2);
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        check("mid_valid", {31'd0, out_valid}, 32'd0);
        check("mid_data",  out_data, 32'd0);
        check("mid_idx",   {30'd0, out_idx}, 32'd0);
        check("mid_last",  {31'd0, out_last}, 32'd0);
        check("mid_busy",  {31'd0, busy}, 32'd0);
        reset = 1'b0;
        sb_q.delete();
        tick();
        out_ready = 1'b1;
        capture(vecs[2].bus, 1'b1, vecs[2].w0, vecs[2].w1, vecs[2].w2, vecs[2].w3);
        tick();
        done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("post_rst_data", out_data, vec_word(vecs[2], k));
            tick();
        end
        check("post_rst_valid_end", {31'd0, out_valid}, 32'd0);
        check("post_rst_busy_end",  {31'd0, busy}, 32'd0);
        tick();
        check("sb_empty_final", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_drain.md
Name: result_drain

Overview:
- Read-side counterpart of the systolic-array controller's load path: drains the N_OUT result words into a single-word valid/ready output stream.
- The controller pulses `done` with all results presented on a packed bus. This block captures them into a double-buffered holding bank and emits them in index order.
- Downstream consumers (host port, result memory, checker) then pull one word per accepted beat.

Parameters:
- DATA_W, 32, width of one result word (IEEE-754 single).
- N_OUT, 4, result words per capture.
- IDX_W, 2, width of out_idx; must equal clog2(N_OUT), minimum 1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- done  input  1  single-cycle capture strobe from the controller.
- res_bus  input  N_OUT*DATA_W  result words; word k at bits [k*DATA_W +: DATA_W]; word 0 = first result.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  DATA_W  current result word.
- out_idx  output  IDX_W  index of out_data within its capture.
- out_last  output  1  high with out_valid on word N_OUT-1.
- busy  output  1  active bank or pending bank occupied.
- overrun  output  1  sticky: a capture was dropped.

Behaviour:
- Reset (sync, active-high, any state, including mid-drain):
  - out_valid, out_data, out_idx, out_last, busy, overrun all go to 0.
  - Both banks are marked empty; all pending data is discarded.
- Storage: active bank (being drained) and pending bank, each N_OUT x DATA_W, each with an occupied flag.
- A handshake occurs when out_valid && out_ready in the same cycle.
- States:
  - IDLE: active empty, out_valid=0. On done, res_bus loads into active, idx=0, go to DRAIN. out_valid rises the cycle after done (latency 1).
  - DRAIN: out_valid=1, out_data=active[idx], out_last=(idx==N_OUT-1).
    - Handshake with idx<N_OUT-1: idx increments.
    - Handshake on the last word with pending occupied: pending moves to active, idx=0, stay in DRAIN (no bubble).
    - Handshake on the last word with pending empty: go to IDLE, unless done is also asserted that cycle.
- done handling while in DRAIN:
  - Pending empty: capture into pending.
  - Pending full and no last-word handshake this cycle: capture dropped, overrun set to 1 and held until reset.
- done coinciding with the last-word handshake:
  - Pending empty: res_bus loads straight into active, idx=0, stay in DRAIN.
  - Pending full: pending moves to active, res_bus loads into pending, no overrun.
- Stall rule: while out_valid && !out_ready, out_data, out_idx and out_last stay stable. out_valid never drops without a handshake.
- out_ready is ignored while out_valid=0; no combinational path from out_ready to out_valid.
- busy = active occupied OR pending occupied, registered.
- Throughput: one word per cycle with out_ready held high. Back-to-back captures stream with no gaps.
- Data is passed through bit-exact; no arithmetic on words. idx wraps only via reload, never by modulo overflow.

Decomposition:
- Shared package systolic_pkg:
  - Constants DATA_W and N_OUT, shared with the controller.
  - State encoding typedef for IDLE/DRAIN.
  - Helper function for clog2 index width.
- One sub-module, result_bank:
  - N_OUT x DATA_W register file with parallel load from the packed bus, occupied flag, and word-select read port.
  - Instantiated twice (active, pending); copy from pending to active done by parallel load.
- FSM, index counter and overrun logic stay in result_drain.

Test Plan:
- Single capture, ready high: res_bus={40800000,40400000,40000000,3f800000} with done at cycle 0.
  - Out words 3f800000, 40000000, 40400000, 40800000 on cycles 1-4, idx 0-3.
  - out_last only on cycle 4; busy falls on cycle 5.
- Backpressure: same capture with out_ready low for 3 cycles on idx 1.
  - out_data holds 40000000 and out_valid stays 1 throughout.
  - Sequence then completes unchanged.
- Back-to-back: second done (words 0x11..0x14) while draining the first, then a third done with pending full and ready low.
  - First 4 words, then 0x11..0x14 with no bubble.
  - Third capture dropped, overrun=1 and stays 1.
- Coincident event: done asserted the same cycle as the last-word handshake, pending empty.
  - New word 0 appears next cycle with idx=0.
  - out_valid never drops; overrun stays 0.
- Reset mid-drain: reset at idx 2 with pending full.
  - Next cycle all outputs 0 and busy=0.
  - A subsequent done yields only the new capture's words.
